fc10_accum: RTL and testbench



---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc10_accum_if.sv | 28 ++
 rtl/fc_mac_lane.sv | 82 ++++++++
 rtl/fc10_accum.sv | 95 +++++++++
 tb/tb_fc10_accum.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared constants and arithmetic helpers for the 10-class fully-connected output layer.
package fc_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 32;
  localparam int FRAC_DEF    = 16;
  localparam int SAT_W       = 128;

  // Products are 64 bits; the extra bits cover the sum of n of them plus the bias.
  function automatic int acc_width(input int n);
    return 2 * DATA_W + $clog2(n) + 1;
  endfunction

  function automatic logic [DATA_W-1:0] sat32(input logic signed [SAT_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v > 128'sd2147483647) begin
      r = 32'h7FFF_FFFF;
    end else if (v < -128'sd2147483648) begin
      r = 32'h8000_0000;
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc10_accum_if.sv
// Beat input bus and score output bus of fc10_accum.
interface fc10_accum_if;

  logic                                            in_valid;
  logic [fc_pkg::DATA_W-1:0]                       x_in;
  logic [fc_pkg::NUM_CLASSES*fc_pkg::DATA_W-1:0]   w_in;
  logic [fc_pkg::NUM_CLASSES*fc_pkg::DATA_W-1:0]   bias_in;
  logic                                            clear;
  logic                                            out_valid;
  logic [fc_pkg::DATA_W-1:0] d_out_0, d_out_1, d_out_2, d_out_3, d_out_4;
  logic [fc_pkg::DATA_W-1:0] d_out_5, d_out_6, d_out_7, d_out_8, d_out_9;
  logic                                            busy;

  modport master (
    output in_valid, x_in, w_in, bias_in, clear,
    input  out_valid, busy,
    input  d_out_0, d_out_1, d_out_2, d_out_3, d_out_4,
    input  d_out_5, d_out_6, d_out_7, d_out_8, d_out_9
  );

  modport slave (
    input  in_valid, x_in, w_in, bias_in, clear,
    output out_valid, busy,
    output d_out_0, d_out_1, d_out_2, d_out_3, d_out_4,
    output d_out_5, d_out_6, d_out_7, d_out_8, d_out_9
  );

endinterface

// File: rtl/fc_mac_lane.sv
// One class lane: product register, bias-seeded accumulator and rescale/saturate output.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int N_IN = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] bias_i,
  input  logic              load_i,
  input  logic              first_i,
  input  logic              acc_en_i,
  input  logic              acc_first_i,
  input  logic              out_en_i,
  output logic [DATA_W-1:0] d_out_o
);

  localparam int ACC_W = acc_width(N_IN);

  logic signed [2*DATA_W-1:0] prod_q, prod_d, prod_s;
  logic        [DATA_W-1:0]   bias_q, bias_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [DATA_W-1:0]   d_out_q, d_out_d;
  logic signed [ACC_W-1:0]    prod_ext_s, bias_ext_s, shr_s;
  logic signed [SAT_W-1:0]    wide_s;

  assign prod_s     = $signed({{DATA_W{x_i[DATA_W-1]}}, x_i}) *
                      $signed({{DATA_W{w_i[DATA_W-1]}}, w_i});
  assign prod_ext_s = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
  assign bias_ext_s = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} << FRAC;
  assign shr_s      = acc_q >>> FRAC;
  assign wide_s     = {{(SAT_W-ACC_W){shr_s[ACC_W-1]}}, shr_s};

  // Next-state for product, latched bias, accumulator and held score.
  always_comb begin
    prod_d  = prod_q;
    bias_d  = bias_q;
    acc_d   = acc_q;
    d_out_d = d_out_q;
    if (load_i) begin
      prod_d = prod_s;
    end else begin
      prod_d = prod_q;
    end
    if (load_i && first_i) begin
      bias_d = bias_i;
    end else begin
      bias_d = bias_q;
    end
    if (acc_en_i) begin
      acc_d = acc_first_i ? (bias_ext_s + prod_ext_s) : (acc_q + prod_ext_s);
    end else begin
      acc_d = acc_q;
    end
    if (out_en_i) begin
      d_out_d = sat32(wide_s);
    end else begin
      d_out_d = d_out_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      d_out_q <= '0;
    end else begin
      prod_q  <= prod_d;
      bias_q  <= bias_d;
      acc_q   <= acc_d;
      d_out_q <= d_out_d;
    end
  end

  assign d_out_o = d_out_q;

endmodule

// File: rtl/fc10_accum.sv
// Streaming 10-class FC output layer: beat counter, P/A/O pipeline tags and ten MAC lanes.
module fc10_accum
  import fc_pkg::*;
#(
  parameter int N_IN = 16,
  parameter int FRAC = FRAC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fc10_accum_if.slave  bus
);

  localparam int CNT_W = $clog2(N_IN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic p_valid_q, p_valid_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic a_valid_q, a_valid_d, a_last_q, a_last_d;
  logic out_valid_q, out_valid_d;
  logic accept_s, first_s, last_s, acc_en_s, out_en_s;
  logic [DATA_W-1:0] d_s [NUM_CLASSES];

  // Beat acceptance, counter and tag propagation; clear kills tags in P and A.
  always_comb begin
    accept_s    = bus.in_valid & ~bus.clear;
    first_s     = (cnt_q == {CNT_W{1'b0}});
    last_s      = (cnt_q == CNT_W'(N_IN - 1));
    acc_en_s    = p_valid_q & ~bus.clear;
    out_en_s    = a_last_q & ~bus.clear;
    cnt_d       = cnt_q;
    if (bus.clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_d = last_s ? {CNT_W{1'b0}} : (cnt_q + CNT_W'(1));
    end else begin
      cnt_d = cnt_q;
    end
    p_valid_d   = accept_s;
    p_first_d   = accept_s & first_s;
    p_last_d    = accept_s & last_s;
    a_valid_d   = acc_en_s;
    a_last_d    = acc_en_s & p_last_q;
    out_valid_d = out_en_s;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= {CNT_W{1'b0}};
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      a_valid_q   <= 1'b0;
      a_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      a_valid_q   <= a_valid_d;
      a_last_q    <= a_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    fc_mac_lane #(.N_IN(N_IN), .FRAC(FRAC)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .x_i         (bus.x_in),
      .w_i         (bus.w_in[DATA_W*k +: DATA_W]),
      .bias_i      (bus.bias_in[DATA_W*k +: DATA_W]),
      .load_i      (accept_s),
      .first_i     (first_s),
      .acc_en_i    (acc_en_s),
      .acc_first_i (p_first_q),
      .out_en_i    (out_en_s),
      .d_out_o     (d_s[k])
    );
  end

  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (cnt_q != {CNT_W{1'b0}}) | p_valid_q | a_valid_q;
  assign bus.d_out_0   = d_s[0];
  assign bus.d_out_1   = d_s[1];
  assign bus.d_out_2   = d_s[2];
  assign bus.d_out_3   = d_s[3];
  assign bus.d_out_4   = d_s[4];
  assign bus.d_out_5   = d_s[5];
  assign bus.d_out_6   = d_s[6];
  assign bus.d_out_7   = d_s[7];
  assign bus.d_out_8   = d_s[8];
  assign bus.d_out_9   = d_s[9];

endmodule

// File: tb/tb_fc10_accum.sv
// Randomized scoreboard bench for fc10_accum with a wide-integer reference model.
module tb_fc10_accum;

  localparam int N_IN = 4;
  localparam int FRAC = 16;
  localparam int NC   = 10;

  typedef struct {
    logic [31:0] v [NC];
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc10_accum_if bus ();
  fc10_accum #(.N_IN(N_IN), .FRAC(FRAC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int m_idx = 0;
  logic signed [127:0] m_sum [NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] get_d(input int k);
    case (k)
      0: return bus.d_out_0;
      1: return bus.d_out_1;
      2: return bus.d_out_2;
      3: return bus.d_out_3;
      4: return bus.d_out_4;
      5: return bus.d_out_5;
      6: return bus.d_out_6;
      7: return bus.d_out_7;
      8: return bus.d_out_8;
      default: return bus.d_out_9;
    endcase
  endfunction

  function automatic logic [31:0] ref_sat(input logic signed [127:0] v);
    if (v > 128'sd2147483647) return 32'h7FFF_FFFF;
    else if (v < -128'sd2147483648) return 32'h8000_0000;
    else return v[31:0];
  endfunction

  // Drives one accepted beat and updates the sample model; last beat queues the expectation.
  task automatic beat(input logic [31:0] x, input logic [31:0] w [NC], input logic [31:0] b [NC]);
    logic signed [31:0]  s32;
    logic signed [127:0] xl, wl;
    exp_t e;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.clear    = 1'b0;
    bus.x_in     = x;
    for (int k = 0; k < NC; k++) begin
      bus.w_in[32*k +: 32]    = w[k];
      bus.bias_in[32*k +: 32] = (m_idx == 0) ? b[k] : $urandom;
    end
    s32 = x;
    xl  = s32;
    for (int k = 0; k < NC; k++) begin
      if (m_idx == 0) begin
        s32       = b[k];
        m_sum[k]  = s32;
        m_sum[k]  = m_sum[k] * 128'sd65536;
      end
      s32      = w[k];
      wl       = s32;
      m_sum[k] = m_sum[k] + xl * wl;
    end
    m_idx++;
    if (m_idx == N_IN) begin
      for (int k = 0; k < NC; k++) e.v[k] = ref_sat(m_sum[k] >>> FRAC);
      e.cyc = cyc + 3;
      exp_q.push_back(e);
      m_idx = 0;
    end
  endtask

  task automatic idle(input int n, input bit chk_busy);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      bus.x_in     = $urandom;
      for (int k = 0; k < NC; k++) begin
        bus.w_in[32*k +: 32]    = $urandom;
        bus.bias_in[32*k +: 32] = $urandom;
      end
      if (chk_busy) begin
        @(negedge clk);
        chk("busy_mid_sample", {31'd0, bus.busy}, 32'd1);
      end
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.clear    = 1'b1;
    bus.x_in     = $urandom;
    m_idx        = 0;
  endtask

  // Monitor: every pulse must match the oldest queued expectation, values and timing.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < NC; k++) chk($sformatf("d_out_%0d", k), get_d(k), e.v[k]);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wa [NC];
    logic [31:0] ba [NC];
    logic [31:0] za [NC];
    logic [31:0] x;
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.x_in     = 32'd0;
    bus.w_in     = '0;
    bus.bias_in  = '0;
    for (int k = 0; k < NC; k++) za[k] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    for (int k = 0; k < NC; k++) chk("reset_d_out", get_d(k), 32'd0);

    // 1: unit feature, weights k.0, zero bias
    for (int k = 0; k < NC; k++) wa[k] = 32'(k) << 16;
    for (int b = 0; b < N_IN; b++) beat(32'h0001_0000, wa, za);
    idle(6, 1'b0);

    // 2: half feature, weights 2.0, bias -1.0
    for (int k = 0; k < NC; k++) begin wa[k] = 32'h0002_0000; ba[k] = 32'hFFFF_0000; end
    for (int b = 0; b < N_IN; b++) beat(32'h0000_8000, wa, ba);
    idle(6, 1'b0);

    // 3: positive then negative saturation
    for (int k = 0; k < NC; k++) wa[k] = 32'h7FFF_FFFF;
    for (int b = 0; b < N_IN; b++) beat(32'h7FFF_FFFF, wa, za);
    idle(6, 1'b0);
    for (int k = 0; k < NC; k++) wa[k] = 32'h8000_0001;
    for (int b = 0; b < N_IN; b++) beat(32'h7FFF_FFFF, wa, za);
    idle(6, 1'b0);

    // 4: scenario 1 with random bubbles, busy held across gaps
    for (int k = 0; k < NC; k++) wa[k] = 32'(k) << 16;
    for (int b = 0; b < N_IN; b++) begin
      beat(32'h0001_0000, wa, za);
      if (b < N_IN - 1) idle($urandom_range(0, 3), 1'b1);
    end
    idle(1, 1'b1);
    idle(6, 1'b0);

    // 5: back-to-back samples, second must not inherit the first
    for (int b = 0; b < N_IN; b++) beat(32'h0001_0000, wa, za);
    for (int k = 0; k < NC; k++) ba[k] = 32'(k) << 16;
    for (int b = 0; b < N_IN; b++) beat(32'h0000_0000, wa, ba);
    idle(8, 1'b0);

    // 6: partial sample aborted by clear, then a full scenario-2 sample
    for (int b = 0; b < 2; b++) beat(32'h0001_0000, wa, za);
    do_clear();
    for (int k = 0; k < NC; k++) begin wa[k] = 32'h0002_0000; ba[k] = 32'hFFFF_0000; end
    for (int b = 0; b < N_IN; b++) beat(32'h0000_8000, wa, ba);
    idle(8, 1'b0);

    // randomized samples with small Q-format values and random bubbles
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < N_IN; b++) begin
        x = 32'($urandom_range(0, 262143)) - 32'd131072;
        for (int k = 0; k < NC; k++) begin
          wa[k] = (s == 5) ? $urandom : (32'($urandom_range(0, 262143)) - 32'd131072);
          ba[k] = 32'($urandom_range(0, 262143)) - 32'd131072;
        end
        if (s == 5) x = $urandom;
        beat(x, wa, ba);
        idle($urandom_range(0, 2), 1'b0);
      end
    end
    idle(8, 1'b0);

    // reset in the middle of a sample: outputs clear immediately, no pulse follows
    for (int b = 0; b < 2; b++) beat(32'h0001_0000, wa, za);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    m_idx = 0;
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    for (int k = 0; k < NC; k++) chk("rst_d_out", get_d(k), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8, 1'b0);
    @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
